alarm_timer_ctrl: RTL and testbench

- Programmable interval timer and sequencer for the anti-theft alarm FSM.
- Holds four time parameters: arm delay, driver-door delay, passenger-door delay and siren-on time.
- Accepts start/cancel requests from the FSM, counts down in seconds using the 1 Hz tick from the clock divider, and returns a one-cycle expired pulse.
- Sits between the clock divider and the alarm FSM; the whole block runs on the system clock.

---
 rtl/alarm_timer_pkg.sv | 24 ++
 rtl/alarm_timer_ctrl_regfile.sv | 52 +++++
 rtl/alarm_timer_ctrl.sv | 98 +++++++++
 tb/tb_alarm_timer_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/alarm_timer_pkg.sv
// Shared definitions for the alarm timer and the alarm FSM: interval indices,
// timer state encoding and default interval lengths in seconds.
package alarm_timer_pkg;

    localparam int unsigned TW_DEF        = 4;
    localparam int unsigned NUM_PARAMS    = 4;

    localparam int unsigned DEF_ARM_SEC       = 6;
    localparam int unsigned DEF_DRIVER_SEC    = 8;
    localparam int unsigned DEF_PASSENGER_SEC = 15;
    localparam int unsigned DEF_ALARM_ON_SEC  = 10;

    localparam logic [1:0] IDX_ARM       = 2'd0;
    localparam logic [1:0] IDX_DRIVER    = 2'd1;
    localparam logic [1:0] IDX_PASSENGER = 2'd2;
    localparam logic [1:0] IDX_ALARM_ON  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_COUNT  = 2'b01,
        ST_EXPIRE = 2'b10
    } timer_state_e;

endpackage

// File: rtl/alarm_timer_ctrl_regfile.sv
// Four programmable interval registers with a single write port, a
// combinational read port for the countdown loader and a write acknowledge.
module time_param_regfile
    import alarm_timer_pkg::*;
#(
    parameter int unsigned TW            = TW_DEF,
    parameter int unsigned DEF_ARM       = DEF_ARM_SEC,
    parameter int unsigned DEF_DRIVER    = DEF_DRIVER_SEC,
    parameter int unsigned DEF_PASSENGER = DEF_PASSENGER_SEC,
    parameter int unsigned DEF_ALARM_ON  = DEF_ALARM_ON_SEC
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_en,
    input  logic [1:0]    prog_sel,
    input  logic [TW-1:0] prog_val,
    input  logic [1:0]    rd_sel,
    output logic [TW-1:0] rd_val_c,
    output logic          prog_ack
);

    logic [TW-1:0] param_q [NUM_PARAMS];
    logic [TW-1:0] param_d [NUM_PARAMS];
    logic          prog_ack_q;
    logic          prog_ack_d;

    always_comb begin
        param_d    = param_q;
        prog_ack_d = prog_en;
        if (prog_en) begin
            param_d[prog_sel] = prog_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            param_q[IDX_ARM]       <= TW'(DEF_ARM);
            param_q[IDX_DRIVER]    <= TW'(DEF_DRIVER);
            param_q[IDX_PASSENGER] <= TW'(DEF_PASSENGER);
            param_q[IDX_ALARM_ON]  <= TW'(DEF_ALARM_ON);
            prog_ack_q             <= 1'b0;
        end else begin
            param_q    <= param_d;
            prog_ack_q <= prog_ack_d;
        end
    end

    // Read reflects the pre-write value, so a same-edge start loads the old interval.
    assign rd_val_c = param_q[rd_sel];
    assign prog_ack = prog_ack_q;

endmodule

// File: rtl/alarm_timer_ctrl.sv
// Seconds countdown sequencer for the alarm FSM: loads a programmable
// interval on start, decrements on the 1 Hz tick and pulses expired once.
module alarm_timer_ctrl
    import alarm_timer_pkg::*;
#(
    parameter int unsigned TW            = TW_DEF,
    parameter int unsigned DEF_ARM       = DEF_ARM_SEC,
    parameter int unsigned DEF_DRIVER    = DEF_DRIVER_SEC,
    parameter int unsigned DEF_PASSENGER = DEF_PASSENGER_SEC,
    parameter int unsigned DEF_ALARM_ON  = DEF_ALARM_ON_SEC
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick_1hz,
    input  logic          start_timer,
    input  logic [1:0]    interval_sel,
    input  logic          cancel_timer,
    input  logic          prog_en,
    input  logic [1:0]    prog_sel,
    input  logic [TW-1:0] prog_val,
    output logic          expired,
    output logic          busy,
    output logic [TW-1:0] remaining,
    output logic          prog_ack
);

    timer_state_e  state_q, state_d;
    logic [TW-1:0] remaining_q, remaining_d;
    logic          expired_q, expired_d;
    logic          busy_q, busy_d;
    logic [TW-1:0] load_val_c;

    time_param_regfile #(
        .TW            (TW),
        .DEF_ARM       (DEF_ARM),
        .DEF_DRIVER    (DEF_DRIVER),
        .DEF_PASSENGER (DEF_PASSENGER),
        .DEF_ALARM_ON  (DEF_ALARM_ON)
    ) u_params (
        .clk      (clk),
        .rst      (rst),
        .prog_en  (prog_en),
        .prog_sel (prog_sel),
        .prog_val (prog_val),
        .rd_sel   (interval_sel),
        .rd_val_c (load_val_c),
        .prog_ack (prog_ack)
    );

    // Next state: cancel beats start, start beats tick; a zero interval expires immediately.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        if (cancel_timer) begin
            state_d     = ST_IDLE;
            remaining_d = '0;
        end else if (start_timer) begin
            remaining_d = load_val_c;
            state_d     = (load_val_c != '0) ? ST_COUNT : ST_EXPIRE;
        end else begin
            case (state_q)
                ST_COUNT: begin
                    if (tick_1hz) begin
                        if (remaining_q > TW'(1)) begin
                            remaining_d = remaining_q - TW'(1);
                        end else begin
                            remaining_d = '0;
                            state_d     = ST_EXPIRE;
                        end
                    end
                end
                ST_EXPIRE: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
        expired_d = (state_d == ST_EXPIRE);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            expired_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            expired_q   <= expired_d;
            busy_q      <= busy_d;
        end
    end

    assign expired   = expired_q;
    assign busy      = busy_q;
    assign remaining = remaining_q;

endmodule

// File: tb/tb_alarm_timer_ctrl.sv
// Bench for alarm_timer_ctrl: directed scenarios then random traffic, all
// checked against a seconds-level behavioural model of the timer.
module tb_alarm_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz;
    logic       start_timer;
    logic [1:0] interval_sel;
    logic       cancel_timer;
    logic       prog_en;
    logic [1:0] prog_sel;
    logic [3:0] prog_val;
    logic       expired;
    logic       busy;
    logic [3:0] remaining;
    logic       prog_ack;

    int n_cmp = 0;
    int n_mis = 0;

    // Behavioural model: interval table, seconds left, and whether a countdown is live.
    int m_par [4];
    int m_left;
    bit m_running;
    bit m_exp;
    bit m_busy;
    bit m_ack;

    always #5 clk = ~clk;

    alarm_timer_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .tick_1hz     (tick_1hz),
        .start_timer  (start_timer),
        .interval_sel (interval_sel),
        .cancel_timer (cancel_timer),
        .prog_en      (prog_en),
        .prog_sel     (prog_sel),
        .prog_val     (prog_val),
        .expired      (expired),
        .busy         (busy),
        .remaining    (remaining),
        .prog_ack     (prog_ack)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_edge(input bit r, input bit t, input bit s, input int sel,
                                       input bit c, input bit pe, input int ps, input int pv);
        bit fire;
        if (!r) begin
            m_par     = '{6, 8, 15, 10};
            m_left    = 0;
            m_running = 0;
            m_exp     = 0;
            m_busy    = 0;
            m_ack     = 0;
            return;
        end
        fire = 0;
        if (c) begin
            m_running = 0;
            m_left    = 0;
        end else if (s) begin
            m_left    = m_par[sel];
            m_running = (m_left != 0);
            fire      = (m_left == 0);
        end else if (m_running && t) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_running = 0;
                fire      = 1;
            end
        end
        m_exp  = fire;
        m_busy = m_running || fire;
        m_ack  = pe;
        if (pe) m_par[ps] = pv;
    endfunction

    task automatic step(input bit r, input bit t, input bit s, input int sel,
                        input bit c, input bit pe, input int ps, input int pv);
        rst          = r;
        tick_1hz     = t;
        start_timer  = s;
        interval_sel = 2'(sel);
        cancel_timer = c;
        prog_en      = pe;
        prog_sel     = 2'(ps);
        prog_val     = 4'(pv);
        @(posedge clk);
        model_edge(r, t, s, sel, c, pe, ps, pv);
        @(negedge clk);
        chk("expired", int'(expired), int'(m_exp));
        chk("busy", int'(busy), int'(m_busy));
        chk("remaining", int'(remaining), m_left);
        chk("prog_ack", int'(prog_ack), int'(m_ack));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            idle(9);
            step(1, 1, 0, 0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        m_par = '{6, 8, 15, 10};
        m_left = 0; m_running = 0; m_exp = 0; m_busy = 0; m_ack = 0;

        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_remaining", int'(remaining), 0);

        // Default arm interval counts 6 down to 0.
        step(1, 0, 1, 0, 0, 0, 0, 0);
        chk("arm_load", int'(remaining), 6);
        ticks(5);
        chk("arm_after5", int'(remaining), 1);
        ticks(1);
        chk("arm_expired", int'(expired), 1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("arm_exp_drop", int'(expired), 0);
        chk("arm_busy_drop", int'(busy), 0);

        // Reprogram passenger delay, then reset restores the default.
        step(1, 0, 0, 0, 0, 1, 2, 3);
        chk("prog_ack_pulse", int'(prog_ack), 1);
        step(1, 0, 1, 2, 0, 0, 0, 0);
        ticks(3);
        chk("pass3_expired", int'(expired), 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 2, 0, 0, 0, 0);
        chk("pass_default", int'(remaining), 15);
        ticks(15);
        chk("pass15_expired", int'(expired), 1);
        idle(2);

        // Zero interval expires on the cycle after start.
        step(1, 0, 0, 0, 0, 1, 1, 0);
        step(1, 0, 1, 1, 0, 0, 0, 0);
        chk("zero_expired", int'(expired), 1);
        idle(2);

        // Cancel mid-count, later ticks must not revive it.
        step(1, 0, 1, 3, 0, 0, 0, 0);
        ticks(4);
        step(1, 0, 0, 0, 1, 0, 0, 0);
        chk("cancel_rem", int'(remaining), 0);
        ticks(3);

        // Restart mid-count reloads and pulses once.
        step(1, 0, 1, 3, 0, 0, 0, 0);
        ticks(4);
        chk("restart_before", int'(remaining), 6);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        chk("restart_load", int'(remaining), 6);
        ticks(6);
        chk("restart_expired", int'(expired), 1);
        idle(2);

        // Coincident tick and write: load uses old value, no decrement.
        step(1, 1, 1, 0, 0, 1, 0, 2);
        chk("coinc_load", int'(remaining), 6);
        idle(3);
        step(1, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        chk("coinc_newval", int'(remaining), 2);

        // Reset mid-count aborts silently.
        step(1, 0, 1, 3, 0, 0, 0, 0);
        ticks(2);
        step(0, 1, 0, 0, 0, 1, 1, 5);
        chk("midrst_rem", int'(remaining), 0);
        chk("midrst_exp", int'(expired), 0);
        chk("midrst_ack", int'(prog_ack), 0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 19) == 0),
                 int'($urandom_range(0, 3)),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 15) == 0),
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
